// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops plus XLEN-iteration shift-add multiply and restoring divide.
// Latency 1 (short ops) or XLEN+1 (mul/div); in_ready only in IDLE, result held in DONE until out_ready.
module alu_seq #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alu_op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SLT    = 5'd3;
  localparam logic [4:0] OP_SLTU   = 5'd4;
  localparam logic [4:0] OP_XOR    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_OR     = 5'd8;
  localparam logic [4:0] OP_AND    = 5'd9;
  localparam logic [4:0] OP_PASSB  = 5'd10;
  localparam logic [4:0] OP_MUL    = 5'd11;
  localparam logic [4:0] OP_MULH   = 5'd12;
  localparam logic [4:0] OP_MULHSU = 5'd13;
  localparam logic [4:0] OP_MULHU  = 5'd14;
  localparam logic [4:0] OP_DIV    = 5'd15;
  localparam logic [4:0] OP_DIVU   = 5'd16;
  localparam logic [4:0] OP_REM    = 5'd17;
  localparam logic [4:0] OP_REMU   = 5'd18;

  localparam int            CW   = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;

  logic [XLEN-1:0] hi, lo, opnd, a_orig;
  logic [XLEN-1:0] hi_nxt, lo_nxt;
  logic [4:0]      op_q;
  logic            neg_q, neg_r, b_zero;
  logic [CW-1:0]   cnt;

  logic            accept, is_long, is_div, a_sgn, b_sgn, a_neg, b_neg, op_div;
  logic [XLEN-1:0] a_mag, b_mag, alu_res, long_res;
  logic [SHW-1:0]  shamt;

  assign accept  = in_valid && in_ready;
  assign is_long = (alu_op >= OP_MUL) && (alu_op <= OP_REMU);
  assign is_div  = (alu_op >= OP_DIV) && (alu_op <= OP_REMU);
  assign shamt   = src_b[SHW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = is_long ? CALC : DONE;
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    alu_res = src_a + src_b;
    case (alu_op)
      OP_SUB:   alu_res = src_a - src_b;
      OP_SLL:   alu_res = src_a << shamt;
      OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
      OP_XOR:   alu_res = src_a ^ src_b;
      OP_SRL:   alu_res = src_a >> shamt;
      OP_SRA:   alu_res = $unsigned($signed(src_a) >>> shamt);
      OP_OR:    alu_res = src_a | src_b;
      OP_AND:   alu_res = src_a & src_b;
      OP_PASSB: alu_res = src_b;
      default:  ;
    endcase
  end

  // Signed variants iterate on magnitudes; the sign is restored when the result is registered.
  assign a_sgn = (alu_op == OP_MULH) || (alu_op == OP_MULHSU) || (alu_op == OP_DIV) || (alu_op == OP_REM);
  assign b_sgn = (alu_op == OP_MULH) || (alu_op == OP_DIV) || (alu_op == OP_REM);
  assign a_neg = a_sgn && src_a[XLEN-1];
  assign b_neg = b_sgn && src_b[XLEN-1];
  assign a_mag = a_neg ? -src_a : src_a;
  assign b_mag = b_neg ? -src_b : src_b;

  logic [XLEN:0] m_sum, d_shift, d_diff;
  assign op_div  = (op_q >= OP_DIV);
  assign m_sum   = {1'b0, hi} + {1'b0, (lo[0] ? opnd : {XLEN{1'b0}})};
  assign d_shift = {hi, lo[XLEN-1]};
  assign d_diff  = d_shift - {1'b0, opnd};

  always_comb begin
    if (op_div) begin
      if (!d_diff[XLEN]) begin
        hi_nxt = d_diff[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_nxt = d_shift[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_nxt = m_sum[XLEN:1];
      lo_nxt = {m_sum[0], lo[XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  assign prod     = {hi_nxt, lo_nxt};
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = neg_q ? -lo_nxt : lo_nxt;
  assign rem_fix  = neg_r ? -hi_nxt : hi_nxt;

  always_comb begin
    long_res = lo_nxt;
    case (op_q)
      OP_MUL:                       long_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: long_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV:                       long_res = b_zero ? {XLEN{1'b1}} : quo_fix;
      OP_DIVU:                      long_res = lo_nxt;
      OP_REM:                       long_res = b_zero ? a_orig : rem_fix;
      OP_REMU:                      long_res = hi_nxt;
      default:                      ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      hi     <= '0;
      lo     <= '0;
      opnd   <= '0;
      a_orig <= '0;
      op_q   <= OP_ADD;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      op_q   <= alu_op;
      a_orig <= src_a;
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      b_zero <= (src_b == '0);
      cnt    <= '0;
      hi     <= '0;
      lo     <= is_div ? a_mag : b_mag;
      opnd   <= is_div ? b_mag : a_mag;
      if (!is_long) result <= alu_res;
    end else if (state == CALC) begin
      hi  <= hi_nxt;
      lo  <= lo_nxt;
      cnt <= cnt + 1'b1;
      if (cnt == LAST) result <= long_res;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: 32-bit instance for the main vectors plus an 8-bit instance.
module tb_alu_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [4:0]  alu_op;
  logic [31:0] src_a, src_b, result;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [4:0]  alu_op8;
  logic [7:0]  src_a8, src_b8, result8;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] res;
  int lat, bc;

  always #5 clk = ~clk;

  alu_seq #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .src_a(src_a), .src_b(src_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  alu_seq #(.XLEN(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .alu_op(alu_op8), .src_a(src_a8), .src_b(src_b8), .out_valid(out_valid8),
    .out_ready(out_ready8), .result(result8), .busy(busy8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one request, return result, cycles from accept to out_valid, and busy cycle count.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output int l, output int bcnt);
    @(negedge clk);
    alu_op = op; src_a = a; src_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    l = 1;
    bcnt = int'(busy);
    while (!out_valid && l < 200) begin
      @(posedge clk); #1;
      l++;
      bcnt += int'(busy);
    end
    r = result;
  endtask

  task automatic handoff();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                     input string tag, input logic [31:0] exp, input int exp_lat);
    issue(op, a, b, res, lat, bc);
    check(tag, res, exp);
    check({tag, "_lat"}, lat, exp_lat);
    handoff();
  endtask

  task automatic run8(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                      input string tag, input logic [7:0] exp, input int exp_lat);
    int l;
    @(negedge clk);
    alu_op8 = op; src_a8 = a; src_b8 = b; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    l = 1;
    while (!out_valid8 && l < 50) begin
      @(posedge clk); #1;
      l++;
    end
    check(tag, result8, exp);
    check({tag, "_lat"}, l, exp_lat);
    @(negedge clk);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; alu_op = '0; src_a = '0; src_b = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; alu_op8 = '0; src_a8 = '0; src_b8 = '0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_result8", result8, 0);
    @(negedge clk);
    rst = 1'b0;

    run(5'd0,  32'h7FFF_FFFF, 32'h1,         "add_ovf",  32'h8000_0000, 1);
    run(5'd7,  32'h8000_0000, 32'h24,        "sra",      32'hF800_0000, 1);
    run(5'd6,  32'h8000_0000, 32'h21,        "srl",      32'h4000_0000, 1);
    run(5'd1,  32'h0,         32'h1,         "sub_wrap", 32'hFFFF_FFFF, 1);
    run(5'd3,  32'hFFFF_FFFF, 32'h1,         "slt",      32'h1,         1);
    run(5'd4,  32'hFFFF_FFFF, 32'h1,         "sltu",     32'h0,         1);
    run(5'd25, 32'h2,         32'h3,         "op25_add", 32'h5,         1);
    check("idle_after_handoff", out_valid, 0);

    issue(5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, bc);
    check("mul", res, 32'h1);
    check("mul_lat", lat, 33);
    check("mul_busy", bc, 32);
    handoff();
    run(5'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu",  32'hFFFF_FFFE, 33);
    run(5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh",   32'h0,         33);
    run(5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu", 32'hFFFF_FFFF, 33);

    run(5'd15, 32'hFFFF_FFF9, 32'h2,         "div_neg",  32'hFFFF_FFFD, 33);
    run(5'd17, 32'hFFFF_FFF9, 32'h2,         "rem_neg",  32'hFFFF_FFFF, 33);
    run(5'd16, 32'h5,         32'h0,         "divu_z",   32'hFFFF_FFFF, 33);
    run(5'd18, 32'h5,         32'h0,         "remu_z",   32'h5,         33);
    run(5'd15, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf",  32'h8000_0000, 33);
    run(5'd17, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf",  32'h0,         33);
    run(5'd15, 32'hFFFF_FFF9, 32'h0,         "div_z_neg", 32'hFFFF_FFFF, 33);
    run(5'd17, 32'hFFFF_FFF9, 32'h0,         "rem_z_neg", 32'hFFFF_FFF9, 33);

    // Hold result under backpressure while inputs churn and a request is pending.
    issue(5'd0, 32'd10, 32'd20, res, lat, bc);
    check("hold_first", res, 32'd30);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      src_a = ~src_a; alu_op = 5'd1; in_valid = 1'b1;
      @(posedge clk); #1;
      check("hold_result", result, 32'd30);
      check("hold_in_ready", in_ready, 0);
      check("hold_out_valid", out_valid, 1);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
    @(posedge clk); #1;
    check("no_second_accept", out_valid, 0);

    // Asynchronous reset part way through a DIVU.
    @(negedge clk);
    alu_op = 5'd16; src_a = 32'd100; src_b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("divu_busy_mid", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_result", result, 0);
    check("arst_in_ready", in_ready, 1);
    @(negedge clk);
    alu_op = 5'd0; src_a = 32'd1; src_b = 32'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    check("ignored_in_rst", out_valid, 0);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle", out_valid, 0);
    run(5'd0, 32'd3, 32'd4, "add_after_rst", 32'd7, 1);

    run8(5'd14, 8'hFF, 8'hFF, "mulhu8", 8'hFE, 9);
    run8(5'd2,  8'h01, 8'h0B, "sll8",   8'h08, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter XLEN, default 32, operand and result width in bits; legal values 8, 16, 32, 64.
REQ-002 Parameter SHW, default $clog2(XLEN), shift-amount width taken from src_b low bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  operation request present.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 alu_op  input  5  operation select, encoding per REQ-013.
REQ-008 src_a  input  XLEN  operand A.
REQ-009 src_b  input  XLEN  operand B.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer takes result this cycle.
REQ-012 result  output  XLEN  registered result; busy  output  1  high in CALC state.

Function
REQ-013 Opcodes SHALL be: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB, 11 MUL, 12 MULH, 13 MULHSU, 14 MULHU, 15 DIV, 16 DIVU, 17 REM, 18 REMU; codes 19-31 SHALL behave as ADD.
REQ-014 All shifts (SLL, SRL, SRA) SHALL use only src_b[SHW-1:0]; SRA SHALL replicate src_a[XLEN-1].
REQ-015 SLT/SLTU SHALL return 1 or 0 zero-extended to XLEN; ADD/SUB SHALL wrap modulo 2^XLEN.
REQ-016 FSM states SHALL be IDLE, CALC, DONE; handshake transfer occurs when in_valid && in_ready, or out_valid && out_ready.
REQ-017 in_ready SHALL equal (state==IDLE); no request SHALL be accepted in CALC or DONE.
REQ-018 Ops 0-10 and 19-31 on accept SHALL go IDLE->DONE, result registered, out_valid high the cycle after accept (latency 1).
REQ-019 Ops 11-18 on accept SHALL latch operands, go IDLE->CALC, run exactly XLEN iteration cycles (shift-add multiply, restoring divide, one bit per cycle), then CALC->DONE; out_valid high XLEN+1 cycles after accept.
REQ-020 MUL SHALL return low XLEN bits of the product; MULH/MULHSU/MULHU high XLEN bits with signed*signed, signed*unsigned, unsigned*unsigned operands.
REQ-021 DIV/REM SHALL truncate toward zero, REM sign follows dividend; signed ops SHALL iterate on magnitudes and fix signs at DONE entry.
REQ-022 Divide by zero SHALL give DIV/DIVU = all ones, REM/REMU = src_a, with no extra latency.
REQ-023 Signed overflow (src_a = most negative, src_b = -1) SHALL give DIV = src_a, REM = 0.
REQ-024 In DONE, result and out_valid SHALL hold stable until out_ready; on out_ready go DONE->IDLE, out_valid low next cycle.
REQ-025 Input changes on src_a/src_b/alu_op while not accepting SHALL not affect an in-flight or held result.
REQ-026 No back-to-back accept in the same cycle as a result handoff; minimum throughput one op per 2 cycles.

Reset
REQ-027 rst high SHALL immediately force state IDLE, out_valid 0, busy 0, result 0, iteration counter 0, independent of clk.
REQ-028 rst asserted during CALC or DONE SHALL abort the operation with no result delivered; first accept allowed on first rising edge after rst deasserts.
REQ-029 in_ready SHALL be 1 while rst is high; requests presented while rst high SHALL be ignored.

Verification
REQ-030 XLEN=32, ADD 0x7FFFFFFF+1, out_ready=1 -> out_valid 1 cycle after accept, result 0x80000000; SRA 0x80000000 by src_b=0x24 -> 0xF8000000 (shift 4).
REQ-031 MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001 at accept+33; MULHU same -> 0xFFFFFFFE; MULH same -> 0x00000000; busy high 32 cycles.
REQ-032 DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
REQ-033 Result ready with out_ready=0 for 5 cycles while src_a toggles and in_valid=1 -> result held, in_ready 0, no second accept; out_ready=1 -> IDLE next cycle.
REQ-034 rst pulsed mid-CALC (cycle 10 of DIVU) -> out_valid, busy, result 0 asynchronously; new ADD 3+4 after release -> 7 at latency 1.
REQ-035 XLEN=8 build: MULHU 0xFF*0xFF -> 0xFE at accept+9; SLL 0x01 by 0x0B -> 0x08.
